// File: rtl/lfsr_capture_pkg.sv
`default_nettype none
// ============================================================================
// lfsr_capture_pkg : shared types and helpers for lfsr_symbol_capture
// Revision: 1.0
// ============================================================================
package lfsr_capture_pkg;

    localparam int LFSR_W_DEF = 5;
    localparam int SAT_W      = 64;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } cap_state_e;

    // Counters narrower than SAT_W are widened by the caller and cast back.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] max_val);
        if (value >= max_val) begin
            return max_val;
        end
        return value + SAT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : two-flop per-bit synchronizer, asynchronous active-low reset
// Revision: 1.0
// ============================================================================
module sync_2ff
    import lfsr_capture_pkg::*;
#(
    parameter int WIDTH = LFSR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_symbol_capture.sv
`default_nettype none
// ============================================================================
// lfsr_symbol_capture : captures each settled slow-LFSR state once as a
// valid/ready symbol, measures symbol period, counts overruns.
// Optional lockup output: define LFSR_LOCKUP_DETECT_EN.
// Revision: 1.0
// ============================================================================
module lfsr_symbol_capture
    import lfsr_capture_pkg::*;
#(
    parameter int LFSR_W        = LFSR_W_DEF,
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 32,
    parameter int OVR_W         = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LFSR_W-1:0]   lfsr_in,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [LFSR_W-1:0]   out_word,
    output logic                out_bit,
    output logic [PERIOD_W-1:0] out_period,
    output logic [OVR_W-1:0]    overrun_cnt
`ifdef LFSR_LOCKUP_DETECT_EN
    ,
    output logic                lockup
`endif
);

    localparam int                   STAB_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0]    STAB_MAX   = STAB_W'(STABLE_CYCLES);
    localparam logic [PERIOD_W-1:0]  PERIOD_MAX = '1;
    localparam logic [OVR_W-1:0]     OVR_MAX    = '1;

    logic [LFSR_W-1:0]   sync_word;
    cap_state_e          state_q,      state_d;
    logic [LFSR_W-1:0]   cand_q,       cand_d;
    logic [LFSR_W-1:0]   last_q,       last_d;
    logic [STAB_W-1:0]   stab_q,       stab_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [PERIOD_W-1:0] period_q,     period_d;
    logic                valid_q,      valid_d;
    logic [LFSR_W-1:0]   word_q,       word_d;
    logic [OVR_W-1:0]    ovr_q,        ovr_d;
    logic                capture;
    logic                drain;

    sync_2ff #(
        .WIDTH (LFSR_W)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (lfsr_in),
        .q_o (sync_word)
    );

    // Any movement of the synchronized word restarts settling, so a skewed
    // multi-bit transition is only captured once every bit has landed.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        last_d  = last_q;
        stab_d  = stab_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_word != last_q) begin
                    cand_d  = sync_word;
                    stab_d  = STAB_W'(1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sync_word != cand_q) begin
                    cand_d = sync_word;
                    stab_d = STAB_W'(1);
                end else if (stab_q < STAB_MAX) begin
                    stab_d = stab_q + STAB_W'(1);
                end else begin
                    capture = 1'b1;
                    last_d  = cand_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drain        = valid_q & out_ready;
        valid_d      = valid_q;
        word_d       = word_q;
        ovr_d        = ovr_q;
        period_d     = period_q;
        period_cnt_d = PERIOD_W'(sat_inc(SAT_W'(period_cnt_q), SAT_W'(PERIOD_MAX)));
        if (drain) begin
            valid_d = 1'b0;
        end
        if (capture) begin
            period_d     = period_cnt_q;
            period_cnt_d = PERIOD_W'(1);
            if (!valid_q || drain) begin
                valid_d = 1'b1;
                word_d  = cand_q;
            end else begin
                ovr_d = OVR_W'(sat_inc(SAT_W'(ovr_q), SAT_W'(OVR_MAX)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cand_q       <= '0;
            last_q       <= '0;
            stab_q       <= '0;
            period_cnt_q <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            word_q       <= '0;
            ovr_q        <= '0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            last_q       <= last_d;
            stab_q       <= stab_d;
            period_cnt_q <= period_cnt_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            word_q       <= word_d;
            ovr_q        <= ovr_d;
        end
    end

`ifdef LFSR_LOCKUP_DETECT_EN
    logic lockup_q, lockup_d;

    // A capture always restarts the period counter, so it decides lockup alone.
    always_comb begin
        lockup_d = lockup_q;
        if (period_cnt_q == PERIOD_MAX) begin
            lockup_d = 1'b1;
        end
        if (capture) begin
            lockup_d = (cand_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= lockup_d;
        end
    end

    assign lockup = lockup_q;
`endif

    assign out_valid   = valid_q;
    assign out_word    = word_q;
    assign out_bit     = word_q[0];
    assign out_period  = period_q;
    assign overrun_cnt = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_symbol_capture.sv
`default_nettype none
// ============================================================================
// tb_lfsr_symbol_capture : scoreboard bench, input-run reference model
// Revision: 1.0
// ============================================================================
module tb_lfsr_symbol_capture;

    localparam int LFSR_W        = 5;
    localparam int STABLE_CYCLES = 4;
    localparam int PERIOD_W      = 32;
    localparam int OVR_W         = 8;

    logic                clk       = 1'b0;
    logic                rst       = 1'b0;
    logic [LFSR_W-1:0]   lfsr_in   = '0;
    logic                out_ready = 1'b1;
    logic                out_valid;
    logic [LFSR_W-1:0]   out_word;
    logic                out_bit;
    logic [PERIOD_W-1:0] out_period;
    logic [OVR_W-1:0]    overrun_cnt;
`ifdef LFSR_LOCKUP_DETECT_EN
    logic                lockup;
`endif

    lfsr_symbol_capture #(
        .LFSR_W        (LFSR_W),
        .STABLE_CYCLES (STABLE_CYCLES),
        .PERIOD_W      (PERIOD_W),
        .OVR_W         (OVR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lfsr_in     (lfsr_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_word    (out_word),
        .out_bit     (out_bit),
        .out_period  (out_period),
        .overrun_cnt (overrun_cnt)
`ifdef LFSR_LOCKUP_DETECT_EN
        ,
        .lockup      (lockup)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a maximal run of identical input samples becomes one
    // symbol once it is STABLE_CYCLES+1 samples long, emitted two edges later
    // (synchronizer). The run alive at reset is treated as already reported.
    typedef struct {
        int unsigned     edge_no;
        logic [LFSR_W-1:0] word;
    } cap_t;

    cap_t              capq[$];
    cap_t              cur_cap;
    logic [LFSR_W-1:0] expq[$];
    int unsigned       cyc, last_cap, m_period, run_len, m_ovr;
    logic [LFSR_W-1:0] run_val;
    bit                run_done, m_occ;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc      = 0;
            last_cap = 1;
            m_period = 0;
            m_ovr    = 0;
            m_occ    = 1'b0;
            run_val  = '0;
            run_len  = STABLE_CYCLES + 1;
            run_done = 1'b1;
            capq.delete();
            expq.delete();
        end else begin
            cyc++;
            if (capq.size() > 0 && capq[0].edge_no == cyc) begin
                cur_cap  = capq.pop_front();
                m_period = cyc - last_cap;
                last_cap = cyc;
                if (!m_occ || out_ready) begin
                    m_occ = 1'b1;
                    expq.push_back(cur_cap.word);
                end else if (m_ovr < 255) begin
                    m_ovr++;
                end
            end else if (m_occ && out_ready) begin
                m_occ = 1'b0;
            end
            if (lfsr_in == run_val) begin
                if (run_len < 1000000) run_len++;
            end else begin
                run_val  = lfsr_in;
                run_len  = 1;
                run_done = 1'b0;
            end
            if (!run_done && run_len == STABLE_CYCLES + 1) begin
                capq.push_back('{edge_no: cyc + 2, word: run_val});
                run_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", 64'(out_valid), 64'(m_occ));
        chk("period", 64'(out_period), 64'(m_period));
        chk("overrun", 64'(overrun_cnt), 64'(m_ovr));
        if (out_valid && expq.size() > 0) begin
            chk("word", 64'(out_word), 64'(expq[0]));
            chk("bit", 64'(out_bit), 64'(expq[0][0]));
            if (out_ready) void'(expq.pop_front());
        end
    end

    task automatic hold(input logic [LFSR_W-1:0] w, input int n, input bit rnd_ready);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            lfsr_in = w;
            if (rnd_ready) out_ready = ($urandom_range(3) != 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [LFSR_W-1:0] w;
        int                n;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        hold(5'h00, 100, 1'b0);
        chk("idle_no_valid", 64'(out_valid), 64'd0);
        chk("idle_period", 64'(out_period), 64'd0);

        hold(5'h08, 20, 1'b0);
        hold(5'h14, 2, 1'b0);
        hold(5'h08, 2, 1'b0);
        hold(5'h14, 2, 1'b0);
        hold(5'h08, 2, 1'b0);
        hold(5'h14, 20, 1'b0);
        chk("toggle_settled_word", 64'(out_word), 64'h14);

        out_ready = 1'b0;
        hold(5'h04, 20, 1'b0);
        hold(5'h12, 20, 1'b0);
        hold(5'h09, 20, 1'b0);
        chk("stall_word", 64'(out_word), 64'h04);
        chk("stall_overruns", 64'(overrun_cnt), 64'd2);
        out_ready = 1'b1;
        hold(5'h09, 3, 1'b0);
        chk("drained", 64'(out_valid), 64'd0);

        hold(5'h11, 1000, 1'b0);
        hold(5'h1E, 1000, 1'b0);
        hold(5'h03, 1000, 1'b0);
        chk("period_1000", 64'(out_period), 64'd1000);

        for (int k = 0; k < 300; k++) begin
            w = 5'($urandom_range(31));
            if ($urandom_range(9) == 0) w = '0;
            n = ($urandom_range(9) < 3) ? $urandom_range(1, 3) : $urandom_range(5, 14);
            hold(w, n, 1'b1);
        end

        out_ready = 1'b0;
        hold(5'h1B, 12, 1'b0);
        #1;
        rst     = 1'b0;
        lfsr_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_clears_valid", 64'(out_valid), 64'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        hold(5'h00, 30, 1'b0);
        chk("post_reset_no_valid", 64'(out_valid), 64'd0);

        for (int k = 0; k < 60; k++) begin
            w = 5'($urandom_range(31));
            n = $urandom_range(1, 12);
            hold(w, n, 1'b1);
        end
        out_ready = 1'b1;
        hold(w, 30, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_symbol_capture.md
Name: lfsr_symbol_capture

Overview:
- Sits directly downstream of the 5-bit slow-clocked LFSR. It consumes that LFSR's parallel output, which is updated by a divided clock and is asynchronous to `clk`.
- Brings the word into the `clk` domain, waits until the multi-bit value is stable, then presents each new LFSR state exactly once as a symbol on a valid/ready interface.
- The consumer is the modulation stage, which uses `out_bit` as the modulation control.
- Also measures the symbol period and counts overruns.

Parameters:
- LFSR_W, 5, width of the LFSR word.
- STABLE_CYCLES, 4, number of consecutive `clk` cycles the synchronized word must hold before capture (minimum 1).
- PERIOD_W, 32, width of the symbol-period measurement.
- OVR_W, 8, width of the overrun counter.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous reset, active-low.
- lfsr_in  in  LFSR_W  LFSR state word, asynchronous to clk.
- out_ready  in  1  consumer accepts the symbol this cycle.
- out_valid  out  1  symbol available.
- out_word  out  LFSR_W  captured LFSR state.
- out_bit  out  1  equals out_word[0]; the modulation bit.
- out_period  out  PERIOD_W  clk cycles between the last two captures.
- overrun_cnt  out  OVR_W  symbols dropped because the output register was occupied.

Behaviour:
- Reset (rst low, asynchronous) values:
  - All outputs 0.
  - Synchronizer flops 0.
  - last_word 0.
  - stab_cnt 0.
  - period counter 0.
  - FSM in IDLE.
- Synchronizer:
  - Two flops per bit; sync2 is the domain-crossed word.
  - No combinational use of lfsr_in.
- FSM states: IDLE, SETTLE.
  - IDLE: when sync2 differs from last_word, load cand <= sync2, set stab_cnt <= 1, go to SETTLE.
  - SETTLE, sync2 differs from cand: reload cand <= sync2, set stab_cnt <= 1, stay in SETTLE (glitch or skew restarts settling).
  - SETTLE, sync2 equals cand, stab_cnt < STABLE_CYCLES: increment stab_cnt.
  - SETTLE, sync2 equals cand, stab_cnt == STABLE_CYCLES: issue a capture event, set last_word <= cand, go to IDLE.
  - SETTLE, cand returns to last_word before capture: still captured. Every settled value is one symbol.
- Latency: a clean lfsr_in change produces out_valid high after exactly STABLE_CYCLES+3 rising clk edges.
- Output register (one entry), on a capture event:
  - Empty (out_valid=0), or being drained this cycle (out_valid & out_ready): load out_word/out_bit from cand and set out_valid=1.
  - Otherwise: keep the old symbol and increment overrun_cnt, saturating at all-ones.
  - last_word updates in both cases.
- Handshake:
  - out_valid stays high and out_word stays stable until out_valid & out_ready.
  - On acceptance with no simultaneous capture, out_valid drops the next cycle.
  - out_ready while out_valid=0 is ignored.
- Period measurement:
  - period counter increments every cycle, saturating at 2^PERIOD_W-1.
  - On a capture event (loaded or dropped): out_period <= counter, counter <= 1.
  - The first out_period after reset is the cycles since reset.
- An LFSR word equal to the reset value 0 is never reported unless a nonzero word precedes it.
- Reset asserted mid-operation: pending symbol lost, counters cleared, no spurious out_valid after release.

Optional Feature:
- Macro: LFSR_LOCKUP_DETECT_EN.
- Defined:
  - Adds output port lockup (1 bit, reset 0).
  - lockup asserts when no capture event occurs for 2^PERIOD_W-1 cycles (period counter saturated) or when a captured word is all-zeros.
  - Clears on the next capture of a nonzero word.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package lfsr_capture_pkg holds:
  - The FSM state enum (IDLE, SETTLE).
  - Localparam LFSR_W_DEF=5.
  - Function sat_inc for the saturating counters.
- One sub-module: sync_2ff, parameterised by width, async active-low reset. Instantiated once for lfsr_in.

Test Plan (STABLE_CYCLES=4, PERIOD_W=32, out_ready=1 unless stated):
- Reset release, lfsr_in held 0 for 100 cycles -> out_valid never asserts, overrun_cnt=0, out_period=0.
- lfsr_in steps 0->5'h08 at edge N -> out_valid=1 at edge N+7, out_word=5'h08, out_bit=0, one-cycle pulse.
- lfsr_in toggles 5'h08->5'h14->5'h08 every 2 cycles for 10 cycles, then holds 5'h14 -> no capture during toggling; single symbol 5'h14 after settling.
- out_ready=0, three distinct stable words spaced 20 cycles apart (5'h04, 5'h12, 5'h09) -> out_word stays 5'h04, overrun_cnt=2; raising out_ready gives one acceptance, then out_valid=0.
- Words spaced 1000 cycles apart -> out_period=1000 on the second and subsequent symbols.
- With LFSR_LOCKUP_DETECT_EN and PERIOD_W=8: no change for 255 cycles -> lockup=1; next nonzero capture -> lockup=0.
